// File: rtl/kmkz_mem_arbiter.sv
// Arbiter sharing one single-port memory bus between the instruction-fetch and data ports.
// Data accesses win unless fetch has been passed over g_im_starve_limit times in a row.
module kmkz_mem_arbiter #(
    parameter int unsigned g_im_starve_limit = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    output logic        bus_we_o,
    output logic        bus_req_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [3:0] STARVE_LIMIT = 4'(g_im_starve_limit);

    typedef enum logic [1:0] {ST_IDLE, ST_IM, ST_DM} state_t;

    state_t      state, state_nx;
    logic        pend_valid, pend_valid_nx, pend_we;
    logic [31:0] pend_addr, pend_wdata, im_tag;
    logic [3:0]  pend_sel, starve_cnt;

    logic        dm_accept, dm_any, grant_dm, dm_ack;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sel;
    logic        req_we;

    logic [31:0] bus_addr_nx, bus_wdata_nx, im_data_nx, dm_data_l_nx;
    logic [3:0]  bus_sel_nx;
    logic        bus_req_nx, bus_we_nx, im_valid_nx;
    logic        dm_load_done_nx, dm_store_done_nx, dm_ready_nx;

    // A request arriving in an IDLE cycle is dispatched straight away so
    // back-to-back data accesses do not lose a cycle to the pending slot.
    assign dm_accept = dm_ready_o & (dm_load_i | dm_store_i);
    assign dm_any    = pend_valid | dm_accept;
    assign grant_dm  = dm_any && (starve_cnt < STARVE_LIMIT);
    assign dm_ack    = (state == ST_DM) && bus_ack_i;

    assign req_addr  = pend_valid ? pend_addr  : dm_addr_i;
    assign req_wdata = pend_valid ? pend_wdata : dm_data_s_i;
    assign req_sel   = pend_valid ? pend_sel   : dm_data_select_i;
    assign req_we    = pend_valid ? pend_we    : dm_store_i;

    assign pend_valid_nx = dm_ack ? 1'b0 : (pend_valid | dm_accept);

    always_ff @(posedge clk_i) begin : state_reg
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin : next_state
        state_nx = state;
        case (state)
            ST_IDLE:      state_nx = grant_dm ? ST_DM : ST_IM;
            ST_IM, ST_DM: if (bus_ack_i) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin : output_logic
        // NOTE: every output gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        bus_req_nx   = (state_nx != ST_IDLE);
        bus_addr_nx  = bus_addr_o;
        bus_wdata_nx = bus_wdata_o;
        bus_sel_nx   = bus_sel_o;
        bus_we_nx    = bus_we_o;
        if (state == ST_IDLE) begin
            if (grant_dm) begin
                bus_addr_nx  = req_addr;
                bus_wdata_nx = req_wdata;
                bus_sel_nx   = req_sel;
                bus_we_nx    = req_we;
            end else begin
                bus_addr_nx  = im_addr_i;
                bus_wdata_nx = '0;
                bus_sel_nx   = 4'hF;
                bus_we_nx    = 1'b0;
            end
        end
        // A fetch whose address moved while in flight is dropped silently.
        im_valid_nx      = (state == ST_IM) && bus_ack_i && (im_addr_i == im_tag);
        im_data_nx       = im_valid_nx ? bus_rdata_i : im_data_o;
        dm_load_done_nx  = dm_ack && !pend_we;
        dm_store_done_nx = dm_ack && pend_we;
        dm_data_l_nx     = dm_load_done_nx ? bus_rdata_i : dm_data_l_o;
        dm_ready_nx      = !pend_valid_nx;
    end

    always_ff @(posedge clk_i) begin : output_reg
        if (!rst_i) begin
            bus_req_o       <= 1'b0;
            bus_addr_o      <= '0;
            bus_wdata_o     <= '0;
            bus_sel_o       <= '0;
            bus_we_o        <= 1'b0;
            im_valid_o      <= 1'b0;
            im_data_o       <= '0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            dm_data_l_o     <= '0;
            dm_ready_o      <= 1'b0;
        end else begin
            bus_req_o       <= bus_req_nx;
            bus_addr_o      <= bus_addr_nx;
            bus_wdata_o     <= bus_wdata_nx;
            bus_sel_o       <= bus_sel_nx;
            bus_we_o        <= bus_we_nx;
            im_valid_o      <= im_valid_nx;
            im_data_o       <= im_data_nx;
            dm_load_done_o  <= dm_load_done_nx;
            dm_store_done_o <= dm_store_done_nx;
            dm_data_l_o     <= dm_data_l_nx;
            dm_ready_o      <= dm_ready_nx;
        end
    end

    always_ff @(posedge clk_i) begin : datapath_reg
        if (!rst_i) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            pend_sel   <= '0;
            pend_we    <= 1'b0;
            starve_cnt <= '0;
            im_tag     <= '0;
        end else begin
            pend_valid <= pend_valid_nx;
            if (dm_accept) begin
                pend_addr  <= dm_addr_i;
                pend_wdata <= dm_data_s_i;
                pend_sel   <= dm_data_select_i;
                pend_we    <= dm_store_i;
            end
            // Counter only increments while below the limit, so it saturates there.
            if (state == ST_IDLE) begin
                if (grant_dm) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end else begin
                    starve_cnt <= '0;
                    im_tag     <= im_addr_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_kmkz_mem_arbiter.sv
// Bench for kmkz_mem_arbiter: behavioural bus slave with a memory model, a data
// scoreboard popped on completion pulses, and a grant log for starvation order.
module tb_kmkz_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] im_addr_i;
    logic [31:0] im_data_o;
    logic        im_valid_o;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_load_i;
    logic        dm_store_i;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_we_o;
    logic        bus_req_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    kmkz_mem_arbiter #(.g_im_starve_limit(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .im_addr_i        (im_addr_i),
        .im_data_o        (im_data_o),
        .im_valid_o       (im_valid_o),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_load_i        (dm_load_i),
        .dm_store_i       (dm_store_i),
        .dm_ready_o       (dm_ready_o),
        .dm_data_l_o      (dm_data_l_o),
        .dm_load_done_o   (dm_load_done_o),
        .dm_store_done_o  (dm_store_done_o),
        .bus_addr_o       (bus_addr_o),
        .bus_wdata_o      (bus_wdata_o),
        .bus_sel_o        (bus_sel_o),
        .bus_we_o         (bus_we_o),
        .bus_req_o        (bus_req_o),
        .bus_ack_i        (bus_ack_i),
        .bus_rdata_i      (bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    localparam int LIMIT = 4;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    typedef struct {
        bit          is_load;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    bit slave_en   = 1'b0;
    int slave_wait = 0;
    int wait_cnt   = 0;

    always @(negedge clk_i) begin : bus_slave
        logic [31:0] mask;
        if (slave_en) begin
            if (bus_req_o && !bus_ack_i) begin
                if (wait_cnt >= slave_wait) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = mem_rd(bus_addr_o);
                    wait_cnt    = 0;
                    if (bus_we_o) begin
                        mask = {{8{bus_sel_o[3]}}, {8{bus_sel_o[2]}}, {8{bus_sel_o[1]}}, {8{bus_sel_o[0]}}};
                        mem[bus_addr_o] = (mem_rd(bus_addr_o) & ~mask) | (bus_wdata_o & mask);
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                bus_ack_i = 1'b0;
                if (!bus_req_o) wait_cnt = 0;
            end
        end
    end

    bit          prev_req = 1'b0;
    logic [68:0] snap;
    bit          grant_log[$];
    int          im_pulses = 0;

    always @(negedge clk_i) begin : monitor
        sb_t e;
        if (bus_req_o && !prev_req) begin
            snap = {bus_addr_o, bus_wdata_o, bus_sel_o, bus_we_o};
            grant_log.push_back(!bus_we_o && bus_addr_o == im_addr_i && bus_sel_o == 4'hF);
        end else if (bus_req_o) begin
            check("bus_hold", 32'({bus_addr_o, bus_wdata_o, bus_sel_o, bus_we_o} == snap), 32'd1);
        end
        prev_req = bus_req_o;
        if (im_valid_o) begin
            im_pulses++;
            check("im_data", im_data_o, mem_rd(im_addr_i));
        end
        if (dm_load_done_o || dm_store_done_o) begin
            if (sb.size() == 0) begin
                check("dm_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("dm_kind", 32'({dm_load_done_o, dm_store_done_o}), e.is_load ? 32'd2 : 32'd1);
                if (e.is_load) check("dm_ldata", dm_data_l_o, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok, seen, bad_ready;
        int first, k, pulses_mark;

        rst_i            = 1'b0;
        im_addr_i        = 32'h100;
        dm_addr_i        = '0;
        dm_data_s_i      = '0;
        dm_data_select_i = '0;
        dm_load_i        = 1'b0;
        dm_store_i       = 1'b0;
        bus_ack_i        = 1'b1;
        bus_rdata_i      = 32'hFFFF_FFFF;
        mem[32'h100]     = 32'h0000_0013;
        mem[32'h200]     = 32'h0000_0093;

        // Reset held with a stray ack: everything quiet, not ready.
        repeat (3) begin
            @(negedge clk_i);
            check("rst_ctl", 32'({bus_req_o, bus_we_o, im_valid_o, dm_load_done_o, dm_store_done_o, dm_ready_o}), 32'd0);
            check("rst_data", bus_addr_o | bus_wdata_o | im_data_o | dm_data_l_o, 32'd0);
            check("rst_sel", 32'(bus_sel_o), 32'd0);
        end
        rst_i      = 1'b1;
        bus_ack_i  = 1'b0;
        slave_wait = 2;
        slave_en   = 1'b1;

        // Fetch only: first grant after release is a fetch of 0x100.
        @(negedge clk_i);
        check("rel_ready", 32'(dm_ready_o), 32'd1);
        check("im_req", 32'(bus_req_o), 32'd1);
        check("im_addr", bus_addr_o, 32'h100);
        check("im_sel", 32'(bus_sel_o), 32'hF);
        check("im_we", 32'(bus_we_o), 32'd0);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (im_valid_o) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
        check("fetch_seen", 32'(ok), 32'd1);
        check("fetch_data", im_data_o, 32'h13);
        @(negedge clk_i);
        check("fetch_one_pulse", 32'(im_valid_o), 32'd0);

        // Address moves while the next fetch is in flight.
        @(negedge clk_i);
        im_addr_i = 32'h200;
        ok = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk_i);
            if (bus_req_o && bus_addr_o == 32'h200) seen = 1'b1;
            if (im_valid_o) begin ok = 1'b1; break; end
        end
        check("chg_pulse_seen", 32'(ok), 32'd1);
        check("chg_req_200", 32'(seen), 32'd1);
        check("chg_data", im_data_o, 32'h93);

        // Store then back-to-back load.
        slave_wait = 1;
        @(negedge clk_i);
        check("st_ready", 32'(dm_ready_o), 32'd1);
        dm_store_i       = 1'b1;
        dm_addr_i        = 32'h40;
        dm_data_s_i      = 32'hDEAD_BEEF;
        dm_data_select_i = 4'b0011;
        sb.push_back('{is_load: 1'b0, data: 32'h0});
        @(negedge clk_i);
        dm_store_i = 1'b0;
        check("st_ready_low", 32'(dm_ready_o), 32'd0);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus_req_o && bus_we_o) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
        check("st_bus_seen", 32'(ok), 32'd1);
        check("st_addr", bus_addr_o, 32'h40);
        check("st_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        check("st_sel", 32'(bus_sel_o), 32'h3);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (dm_ready_o) begin ok = 1'b1; break; end
        end
        check("st_ready_back", 32'(ok), 32'd1);
        check("st_done_with_ready", 32'(dm_store_done_o), 32'd1);

        mem[32'h40]      = 32'h0000_1234;
        dm_load_i        = 1'b1;
        dm_data_select_i = 4'hF;
        sb.push_back('{is_load: 1'b1, data: 32'h1234});
        @(negedge clk_i);
        dm_load_i = 1'b0;
        ok = 1'b0;
        bad_ready = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (dm_load_done_o) begin ok = 1'b1; break; end
            if (dm_ready_o) bad_ready = 1'b1;
            @(negedge clk_i);
        end
        check("ld_done_seen", 32'(ok), 32'd1);
        check("ld_ready_low", 32'(bad_ready), 32'd0);
        check("ld_data", dm_data_l_o, 32'h1234);

        // Continuous loads: grants must run LIMIT data, then one fetch.
        grant_log.delete();
        k = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_i);
            if (dm_ready_o) begin
                dm_load_i = 1'b1;
                dm_addr_i = 32'h800 + 32'(4 * k);
                sb.push_back('{is_load: 1'b1, data: mem_rd(32'h800 + 32'(4 * k))});
                k++;
            end else begin
                dm_load_i = 1'b0;
            end
        end
        @(negedge clk_i);
        dm_load_i = 1'b0;
        first = -1;
        foreach (grant_log[i]) begin
            if (!grant_log[i]) begin first = i; break; end
        end
        check("stv_len", 32'(first >= 0 && grant_log.size() >= first + 15), 32'd1);
        if (first >= 0) begin
            for (int j = 0; j < 15; j++) begin
                if (first + j < grant_log.size())
                    check($sformatf("stv_grant%0d", j), 32'(grant_log[first + j]), 32'((j % (LIMIT + 1)) == LIMIT));
            end
        end
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk_i);
            if (sb.size() == 0 && dm_ready_o) begin ok = 1'b1; break; end
        end
        check("stv_drain", 32'(ok), 32'd1);

        // Reset while a load is on the bus; late ack afterwards.
        dm_load_i = 1'b1;
        dm_addr_i = 32'h900;
        @(negedge clk_i);
        dm_load_i = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus_req_o && bus_addr_o == 32'h900) begin ok = 1'b1; break; end
            @(negedge clk_i);
        end
        check("rdm_on_bus", 32'(ok), 32'd1);
        slave_wait = 40;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rdm_req_drop", 32'(bus_req_o), 32'd0);
        check("rdm_ready_low", 32'(dm_ready_o), 32'd0);
        check("rdm_no_done", 32'(dm_load_done_o), 32'd0);
        slave_en    = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk_i);
        rst_i = 1'b1;
        check("rdm_no_done2", 32'(dm_load_done_o), 32'd0);
        @(negedge clk_i);
        bus_ack_i = 1'b0;
        pulses_mark = im_pulses;
        check("rdm_rel_ready", 32'(dm_ready_o), 32'd1);
        check("rdm_no_done3", 32'(dm_load_done_o), 32'd0);
        check("rdm_fetch_req", 32'(bus_req_o), 32'd1);
        check("rdm_fetch_addr", bus_addr_o, 32'h200);
        slave_wait = 0;
        slave_en   = 1'b1;
        repeat (8) @(negedge clk_i);
        check("rdm_fetch_resumes", 32'(im_pulses > pulses_mark), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
